// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding, load-use and
// branch hazard handling, multi-cycle multiply sequencing and a stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_WORDS  = 32,
  parameter int unsigned ADDR_LEFT  = $clog2(REG_WORDS) - 1,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEFT:0]  r1_addr_s2,
  input  logic [ADDR_LEFT:0]  r2_addr_s2,
  input  logic                r1_used_s2,
  input  logic                r2_used_s2,
  input  logic [ADDR_LEFT:0]  r1_addr_s3,
  input  logic [ADDR_LEFT:0]  r2_addr_s3,
  input  logic                rw_s3,
  input  logic [ADDR_LEFT:0]  waddr_s3,
  input  logic                mem_rd_s3,
  input  logic                mul_start_s3,
  input  logic                br_taken_s3,
  input  logic                rw_s4,
  input  logic [ADDR_LEFT:0]  waddr_s4,
  input  logic                rw_s5,
  input  logic [ADDR_LEFT:0]  waddr_s5,
  output logic                stall_s1,
  output logic                stall_s2,
  output logic                stall_s3,
  output logic                flush_s2,
  output logic                bubble_s3,
  output logic                bubble_s4,
  output logic [1:0]          fwd_r1_sel,
  output logic [1:0]          fwd_r2_sel,
  output logic                mul_busy,
  output logic                mul_done,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam int unsigned MW = $clog2(MUL_CYCLES);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] mcnt;
  logic          lu;
  logic          mul_last;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_LEFT:0] src);
    if (rw_s4 && waddr_s4 != '0 && src == waddr_s4)      fwd_sel = 2'b01;
    else if (rw_s5 && waddr_s5 != '0 && src == waddr_s5) fwd_sel = 2'b10;
    else                                                 fwd_sel = 2'b00;
  endfunction

  assign lu = mem_rd_s3 && rw_s3 && waddr_s3 != '0 &&
              ((r1_used_s2 && r1_addr_s2 == waddr_s3) ||
               (r2_used_s2 && r2_addr_s2 == waddr_s3));

  assign mul_last = (state == MUL_WAIT) && (mcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      mcnt     <= '0;
      mul_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      mul_done <= mul_last;
      if (state == RUN && mul_start_s3) mcnt <= MW'(MUL_CYCLES - 2);
      else if (state == MUL_WAIT && mcnt != '0) mcnt <= mcnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mul_start_s3) state_nxt = MUL_WAIT;
      MUL_WAIT: if (mcnt == '0) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_s1   = 1'b0;
    stall_s2   = 1'b0;
    stall_s3   = 1'b0;
    flush_s2   = 1'b0;
    bubble_s3  = 1'b0;
    bubble_s4  = 1'b0;
    fwd_r1_sel = 2'b00;
    fwd_r2_sel = 2'b00;
    mul_busy   = 1'b0;
    if (!rst) begin
      fwd_r1_sel = fwd_sel(r1_addr_s3);
      fwd_r2_sel = fwd_sel(r2_addr_s3);
      mul_busy   = (state == MUL_WAIT);
      case (state)
        RUN: begin
          if (mul_start_s3) begin
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            stall_s3  = 1'b1;
            bubble_s4 = 1'b1;
          end else if (br_taken_s3) begin
            flush_s2  = 1'b1;
            bubble_s3 = 1'b1;
          end else if (lu) begin
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            bubble_s3 = 1'b1;
          end
        end
        MUL_WAIT: begin
          // Final multiply cycle releases the pipe so the result leaves EX.
          if (!mul_last) begin
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            stall_s3  = 1'b1;
            bubble_s4 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if (stall_s1 && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, registered effects are checked on the following falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] r1_addr_s2, r2_addr_s2, r1_addr_s3, r2_addr_s3;
  logic       r1_used_s2, r2_used_s2;
  logic       rw_s3, mem_rd_s3, mul_start_s3, br_taken_s3;
  logic [4:0] waddr_s3, waddr_s4, waddr_s5;
  logic       rw_s4, rw_s5;
  logic       stall_s1, stall_s2, stall_s3, flush_s2, bubble_s3, bubble_s4;
  logic [1:0] fwd_r1_sel, fwd_r2_sel;
  logic       mul_busy, mul_done;
  logic [3:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_WORDS(32), .MUL_CYCLES(4), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .r1_addr_s2(r1_addr_s2), .r2_addr_s2(r2_addr_s2),
    .r1_used_s2(r1_used_s2), .r2_used_s2(r2_used_s2),
    .r1_addr_s3(r1_addr_s3), .r2_addr_s3(r2_addr_s3),
    .rw_s3(rw_s3), .waddr_s3(waddr_s3), .mem_rd_s3(mem_rd_s3),
    .mul_start_s3(mul_start_s3), .br_taken_s3(br_taken_s3),
    .rw_s4(rw_s4), .waddr_s4(waddr_s4), .rw_s5(rw_s5), .waddr_s5(waddr_s5),
    .stall_s1(stall_s1), .stall_s2(stall_s2), .stall_s3(stall_s3),
    .flush_s2(flush_s2), .bubble_s3(bubble_s3), .bubble_s4(bubble_s4),
    .fwd_r1_sel(fwd_r1_sel), .fwd_r2_sel(fwd_r2_sel),
    .mul_busy(mul_busy), .mul_done(mul_done), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {r1_addr_s2, r2_addr_s2, r1_addr_s3, r2_addr_s3} = '0;
    {r1_used_s2, r2_used_s2, rw_s3, mem_rd_s3, mul_start_s3, br_taken_s3} = '0;
    {waddr_s3, waddr_s4, waddr_s5, rw_s4, rw_s5} = '0;
  endtask

  task automatic set_lu();
    mem_rd_s3 = 1'b1; rw_s3 = 1'b1; waddr_s3 = 5'd7;
    r2_used_s2 = 1'b1; r2_addr_s2 = 5'd7;
  endtask

  task automatic do_reset();
    @(negedge clk); clear_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Returns {stall_s1, stall_s2, stall_s3, flush_s2, bubble_s3, bubble_s4}
  function automatic logic [5:0] ctl();
    return {stall_s1, stall_s2, stall_s3, flush_s2, bubble_s3, bubble_s4};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // reset holds everything low even with forwarding/hazard inputs active
    rw_s4 = 1'b1; waddr_s4 = 5'd5; r1_addr_s3 = 5'd5; set_lu();
    #1;
    chk("rst_fwd_r1", fwd_r1_sel, 2'b00);
    chk("rst_ctl", ctl(), 6'b000000);
    chk("rst_cnt", stall_cnt, 4'd0);
    chk("rst_busy", mul_busy, 1'b0);
    chk("rst_done", mul_done, 1'b0);

    // 1. forwarding priority
    @(negedge clk); rst = 1'b0; clear_inputs();
    rw_s4 = 1'b1; waddr_s4 = 5'd5; r1_addr_s3 = 5'd5; #1;
    chk("fwd_s4", fwd_r1_sel, 2'b01);
    chk("fwd_r2_none", fwd_r2_sel, 2'b00);
    rw_s5 = 1'b1; waddr_s5 = 5'd5; #1;
    chk("fwd_s4_beats_s5", fwd_r1_sel, 2'b01);
    rw_s4 = 1'b0; r2_addr_s3 = 5'd5; #1;
    chk("fwd_s5", fwd_r1_sel, 2'b10);
    chk("fwd_r2_s5", fwd_r2_sel, 2'b10);
    rw_s4 = 1'b1; waddr_s4 = 5'd0; waddr_s5 = 5'd0; r1_addr_s3 = 5'd0; #1;
    chk("fwd_r0_never", fwd_r1_sel, 2'b00);

    // 2. load-use
    @(negedge clk); clear_inputs(); set_lu(); #1;
    chk("lu_ctl", ctl(), 6'b110010);
    @(negedge clk);
    chk("lu_cnt", stall_cnt, 4'd1);
    waddr_s3 = 5'd0; r2_addr_s2 = 5'd0; #1;
    chk("lu_r0_ctl", ctl(), 6'b000000);
    @(negedge clk);
    chk("lu_r0_cnt", stall_cnt, 4'd1);

    // 3. multiply
    do_reset();
    mul_start_s3 = 1'b1; #1;
    chk("mul_c0_ctl", ctl(), 6'b111001);
    chk("mul_c0_busy", mul_busy, 1'b0);
    @(negedge clk); mul_start_s3 = 1'b0; #1;
    chk("mul_c1_ctl", ctl(), 6'b111001);
    chk("mul_c1_busy", mul_busy, 1'b1);
    @(negedge clk); br_taken_s3 = 1'b1; #1;
    chk("mul_c2_ignore_br", ctl(), 6'b111001);
    @(negedge clk); br_taken_s3 = 1'b0; #1;
    chk("mul_c3_stall", stall_s1, 1'b0);
    chk("mul_c3_busy", mul_busy, 1'b1);
    chk("mul_c3_done", mul_done, 1'b0);
    @(negedge clk); #1;
    chk("mul_c4_done", mul_done, 1'b1);
    chk("mul_c4_busy", mul_busy, 1'b0);
    chk("mul_cnt", stall_cnt, 4'd3);
    @(negedge clk); #1;
    chk("mul_c5_done", mul_done, 1'b0);

    // 4. branch beats load-use
    do_reset();
    br_taken_s3 = 1'b1; set_lu(); #1;
    chk("br_ctl", ctl(), 6'b000110);
    @(negedge clk);
    chk("br_cnt", stall_cnt, 4'd0);

    // 5. reset mid-multiply
    do_reset();
    mul_start_s3 = 1'b1;
    @(negedge clk); mul_start_s3 = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("rstmul_forced", {ctl(), mul_busy}, 7'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmul_busy", mul_busy, 1'b0);
    chk("rstmul_stall", stall_s1, 1'b0);
    chk("rstmul_cnt", stall_cnt, 4'd0);
    chk("rstmul_done", mul_done, 1'b0);
    @(negedge clk); #1;
    chk("rstmul_done_late", mul_done, 1'b0);
    chk("rstmul_busy_late", mul_busy, 1'b0);

    // 6. counter saturation
    do_reset();
    set_lu();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 9) chk("sat_cnt10", stall_cnt, 4'd10);
    end
    chk("sat_cnt20", stall_cnt, 4'd15);
    chk("sat_still_stalling", stall_s1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
